// File: rtl/pavana_slave_arbiter.sv
// Four-master round-robin arbiter onto one slave port, with lock-on-stall, read throttling and response routing.
// Zero-latency accept; a stalled grant is held until accepted; reads are held back while MAX_OUTSTANDING are in flight.
module pavana_slave_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [3:0]   m_req_i,
  input  logic [127:0] m_addr_i,
  input  logic [3:0]   m_cmd_i,
  input  logic [127:0] m_wdata_i,
  output logic [3:0]   m_ack_o,
  output logic [31:0]  m_rdata_o,
  output logic [3:0]   m_resp_o,
  output logic         s_req_o,
  output logic [31:0]  s_addr_o,
  output logic         s_cmd_o,
  output logic [31:0]  s_wdata_o,
  output logic [1:0]   s_reqtid_o,
  input  logic         s_ack_i,
  input  logic         s_resp_i,
  input  logic [1:0]   s_resptid_i,
  input  logic [31:0]  s_rdata_i,
  output logic [3:0]   outstanding_o,
  output logic         err_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t      state;
  logic [1:0]  lock_idx;
  logic [1:0]  last_grant;
  logic [3:0]  outstanding;
  logic        err;

  logic        throttle;
  logic [3:0]  eligible;
  logic        rr_found;
  logic [1:0]  rr_idx;
  logic [1:0]  cand;
  logic [1:0]  grant;
  logic        grant_vld;
  logic        xfer;
  logic        rd_xfer;

  // At the read limit only writes may compete, so a pending write is not starved by a blocked read.
  assign throttle = (outstanding == 4'(MAX_OUTSTANDING));
  assign eligible = m_req_i & (m_cmd_i | {4{~throttle}});

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last_grant + 2'd1;
    cand     = last_grant;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!rr_found && eligible[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign grant     = (state == LOCKED) ? lock_idx : rr_idx;
  assign grant_vld = (state == LOCKED) ? eligible[lock_idx] : rr_found;

  assign s_req_o    = rst_i & grant_vld;
  assign s_addr_o   = m_addr_i[{grant, 5'd0} +: 32];
  assign s_wdata_o  = m_wdata_i[{grant, 5'd0} +: 32];
  assign s_cmd_o    = m_cmd_i[grant];
  assign s_reqtid_o = grant;

  assign xfer    = s_req_o & s_ack_i;
  assign rd_xfer = xfer & ~s_cmd_o;

  assign m_ack_o   = xfer ? (4'b0001 << grant) : 4'b0000;
  assign m_resp_o  = (rst_i & s_resp_i) ? (4'b0001 << s_resptid_i) : 4'b0000;
  assign m_rdata_o = s_rdata_i;

  assign outstanding_o = outstanding;
  assign err_o         = err;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      lock_idx    <= 2'd0;
      last_grant  <= 2'd3;
      outstanding <= 4'd0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_req_o && !s_ack_i) begin
            state    <= LOCKED;
            lock_idx <= grant;
          end
        end
        LOCKED: begin
          // A master withdrawing a stalled request is a protocol violation.
          if (!m_req_i[lock_idx]) begin
            state <= IDLE;
            err   <= 1'b1;
          end else if (xfer) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (xfer)
        last_grant <= grant;

      if (rd_xfer && !s_resp_i)
        outstanding <= outstanding + 4'd1;
      else if (!rd_xfer && s_resp_i && outstanding != 4'd0)
        outstanding <= outstanding - 4'd1;

      if (s_resp_i && outstanding == 4'd0)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pavana_slave_arbiter.sv
// Self-checking bench for pavana_slave_arbiter: vector table, directed lock/throttle/reset sequences,
// and randomized traffic against a queue-based reference model.
module tb_pavana_slave_arbiter;

  localparam int MAXO = 4;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [3:0]   m_req;
  logic [127:0] m_addr;
  logic [3:0]   m_cmd;
  logic [127:0] m_wdata;
  logic [3:0]   m_ack_o;
  logic [31:0]  m_rdata_o;
  logic [3:0]   m_resp_o;
  logic         s_req_o;
  logic [31:0]  s_addr_o;
  logic         s_cmd_o;
  logic [31:0]  s_wdata_o;
  logic [1:0]   s_reqtid_o;
  logic         s_ack;
  logic         s_resp;
  logic [1:0]   s_resptid;
  logic [31:0]  s_rdata;
  logic [3:0]   outstanding_o;
  logic         err_o;

  always #5 clk = ~clk;

  pavana_slave_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_req_i(m_req), .m_addr_i(m_addr), .m_cmd_i(m_cmd), .m_wdata_i(m_wdata),
    .m_ack_o(m_ack_o), .m_rdata_o(m_rdata_o), .m_resp_o(m_resp_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_cmd_o(s_cmd_o), .s_wdata_o(s_wdata_o),
    .s_reqtid_o(s_reqtid_o), .s_ack_i(s_ack), .s_resp_i(s_resp), .s_resptid_i(s_resptid),
    .s_rdata_i(s_rdata), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: in-flight read tags, lock owner, last winner, sticky error.
  int mq[$];
  bit mlocked;
  int mowner;
  int mlast;
  bit merr;
  bit e_sreq;
  int e_g;

  typedef struct {
    logic [3:0] req;
    logic [3:0] cmd;
    logic       ack;
    logic       resp;
    logic [1:0] rtid;
    logic       x_sreq;
    logic [1:0] x_tid;
    logic [3:0] x_ack;
    logic [3:0] x_mresp;
    logic [3:0] x_out;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mlocked = 0;
    mowner  = 0;
    mlast   = 3;
    merr    = 0;
  endtask

  task automatic model_eval();
    bit th;
    th     = (mq.size() == MAXO);
    e_sreq = 0;
    e_g    = 0;
    if (mlocked) begin
      e_g    = mowner;
      e_sreq = m_req[mowner] && (m_cmd[mowner] || !th);
    end else begin
      for (int k = 1; k <= 4; k++) begin
        int n;
        n = (mlast + k) % 4;
        if (!e_sreq && m_req[n] && (m_cmd[n] || !th)) begin
          e_sreq = 1;
          e_g    = n;
        end
      end
    end
  endtask

  task automatic model_check();
    bit xfer;
    xfer = e_sreq && s_ack;
    chk("s_req", 32'(s_req_o), 32'(e_sreq));
    chk("m_ack", 32'(m_ack_o), xfer ? (32'd1 << e_g) : 32'd0);
    chk("m_resp", 32'(m_resp_o), s_resp ? (32'd1 << s_resptid) : 32'd0);
    chk("m_rdata", m_rdata_o, s_rdata);
    chk("outstanding", 32'(outstanding_o), 32'(mq.size()));
    chk("err", 32'(err_o), 32'(merr));
    if (e_sreq) begin
      chk("s_reqtid", 32'(s_reqtid_o), 32'(e_g));
      chk("s_addr", s_addr_o, m_addr[e_g*32 +: 32]);
      chk("s_wdata", s_wdata_o, m_wdata[e_g*32 +: 32]);
      chk("s_cmd", 32'(s_cmd_o), 32'(m_cmd[e_g]));
    end
  endtask

  task automatic model_commit();
    bit xfer;
    bit rd;
    xfer = e_sreq && s_ack;
    rd   = xfer && !m_cmd[e_g];
    if (mlocked) begin
      if (!m_req[mowner]) begin
        mlocked = 0;
        merr    = 1;
      end else if (xfer) begin
        mlocked = 0;
      end
    end else if (e_sreq && !s_ack) begin
      mlocked = 1;
      mowner  = e_g;
    end
    if (xfer) mlast = e_g;
    if (s_resp && mq.size() == 0) merr = 1;
    if (rd && !s_resp) mq.push_back(e_g);
    else if (!rd && s_resp && mq.size() > 0) void'(mq.pop_front());
  endtask

  // Called at posedge+1: settle inputs, compare to model, advance one clock.
  task automatic settle();
    #3;
    model_eval();
    model_check();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_req = 4'h0; m_cmd = 4'h0; s_ack = 1'b0; s_resp = 1'b0; s_resptid = 2'd0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    m_req = 4'hF; m_cmd = 4'h0; s_ack = 1'b1; s_resp = 1'b1; s_resptid = 2'd1;
    #2;
    chk("rst_s_req", 32'(s_req_o), 32'd0);
    chk("rst_m_ack", 32'(m_ack_o), 32'd0);
    chk("rst_m_resp", 32'(m_resp_o), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    idle_inputs();
    rst_i = 1'b1;
    chk("rst_outstanding", 32'(outstanding_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_addr[i*32 +: 32]  = 32'hA000_0000 + 32'(i);
      m_wdata[i*32 +: 32] = 32'h5000_0000 + 32'(i);
    end
    s_rdata = 32'hDEADBEEF;
    idle_inputs();
    rst_i = 1'b1;
    #1;
    do_reset();

    // Fairness, same-cycle accept+response, then throttle with a write bypassing a held read.
    vt[0] = '{4'hF, 4'h0, 1, 0, 2'd0, 1, 2'd0, 4'b0001, 4'b0000, 4'd0};
    vt[1] = '{4'hF, 4'h0, 1, 0, 2'd0, 1, 2'd1, 4'b0010, 4'b0000, 4'd1};
    vt[2] = '{4'hF, 4'h0, 1, 0, 2'd0, 1, 2'd2, 4'b0100, 4'b0000, 4'd2};
    vt[3] = '{4'hF, 4'h0, 1, 1, 2'd2, 1, 2'd3, 4'b1000, 4'b0100, 4'd3};
    vt[4] = '{4'hF, 4'h0, 1, 0, 2'd0, 1, 2'd0, 4'b0001, 4'b0000, 4'd3};
    vt[5] = '{4'hA, 4'h8, 1, 0, 2'd0, 1, 2'd3, 4'b1000, 4'b0000, 4'd4};
    vt[6] = '{4'h2, 4'h0, 1, 1, 2'd0, 0, 2'd0, 4'b0000, 4'b0001, 4'd4};
    vt[7] = '{4'h2, 4'h0, 1, 0, 2'd0, 1, 2'd1, 4'b0010, 4'b0000, 4'd3};
    for (int i = 0; i < 8; i++) begin
      m_req = vt[i].req; m_cmd = vt[i].cmd; s_ack = vt[i].ack;
      s_resp = vt[i].resp; s_resptid = vt[i].rtid;
      settle();
      chk($sformatf("vec%0d_s_req", i), 32'(s_req_o), 32'(vt[i].x_sreq));
      if (vt[i].x_sreq) chk($sformatf("vec%0d_tid", i), 32'(s_reqtid_o), 32'(vt[i].x_tid));
      chk($sformatf("vec%0d_m_ack", i), 32'(m_ack_o), 32'(vt[i].x_ack));
      chk($sformatf("vec%0d_m_resp", i), 32'(m_resp_o), 32'(vt[i].x_mresp));
      chk($sformatf("vec%0d_rdata", i), m_rdata_o, 32'hDEADBEEF);
      chk($sformatf("vec%0d_out", i), 32'(outstanding_o), 32'(vt[i].x_out));
      advance();
    end
    idle_inputs();

    // Lock: master 2 stalls for 3 cycles, master 0 joins, master 2 keeps the slot until accepted.
    do_reset();
    m_req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("lock_tid_stall", 32'(s_reqtid_o), 32'd2);
      advance();
    end
    m_req = 4'b0101;
    settle();
    chk("lock_tid_contend", 32'(s_reqtid_o), 32'd2);
    chk("lock_no_ack", 32'(m_ack_o), 32'd0);
    advance();
    s_ack = 1'b1;
    settle();
    chk("lock_ack_m2", 32'(m_ack_o), 32'b0100);
    advance();
    settle();
    chk("after_lock_tid", 32'(s_reqtid_o), 32'd0);
    chk("after_lock_ack", 32'(m_ack_o), 32'b0001);
    advance();
    idle_inputs();

    // Response with nothing outstanding; no requests pending.
    do_reset();
    s_resp = 1'b1; s_resptid = 2'd1;
    settle();
    chk("idle_s_req", 32'(s_req_o), 32'd0);
    chk("stray_resp_route", 32'(m_resp_o), 32'b0010);
    advance();
    s_resp = 1'b0;
    settle();
    chk("stray_err", 32'(err_o), 32'd1);
    chk("stray_out", 32'(outstanding_o), 32'd0);
    advance();

    // Reset while locked with three reads in flight.
    do_reset();
    m_req = 4'hF; s_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin settle(); advance(); end
    s_ack = 1'b0;
    settle();
    advance();
    settle();
    chk("pre_rst_out", 32'(outstanding_o), 32'd3);
    chk("pre_rst_tid", 32'(s_reqtid_o), 32'd3);
    #1;
    rst_i = 1'b0;
    s_resp = 1'b1;
    #1;
    chk("midrst_s_req", 32'(s_req_o), 32'd0);
    chk("midrst_m_resp", 32'(m_resp_o), 32'd0);
    chk("midrst_out", 32'(outstanding_o), 32'd0);
    chk("midrst_err", 32'(err_o), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_i = 1'b1; s_resp = 1'b0; s_ack = 1'b1;
    settle();
    chk("post_rst_tid", 32'(s_reqtid_o), 32'd0);
    advance();
    idle_inputs();

    // Randomized traffic in segments separated by reset.
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        for (int n = 0; n < 4; n++) begin
          if (!m_req[n]) begin
            if ($urandom_range(1, 0) == 1) begin
              m_req[n] = 1'b1;
              m_cmd[n] = 1'($urandom_range(1, 0));
              m_addr[n*32 +: 32]  = $urandom;
              m_wdata[n*32 +: 32] = $urandom;
            end
          end else if ($urandom_range(15, 0) == 0) begin
            m_req[n] = 1'b0;
          end
        end
        s_ack     = ($urandom_range(9, 0) < 6);
        s_resp    = ($urandom_range(3, 0) == 0);
        s_resptid = 2'($urandom_range(3, 0));
        s_rdata   = $urandom;
        settle();
        advance();
        // Masters that were accepted move on to a fresh request decision.
        for (int n = 0; n < 4; n++)
          if (e_sreq && s_ack && e_g == n) m_req[n] = 1'b0;
      end
      idle_inputs();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pavana_slave_arbiter.md
PAVANA_SLAVE_ARBITER -- requirements
Module: pavana_slave_arbiter

Interface
REQ-001 Parameter: MAX_OUTSTANDING, default 4, maximum accepted reads awaiting response (range 1..15).
REQ-002 clk_i  input  1  sole clock; all state on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 m_req_i  input  4  per-master request, bit n = master n.
REQ-005 m_addr_i  input  128  master n address at [32n+31:32n].
REQ-006 m_cmd_i  input  4  per-master command: 1 = write, 0 = read.
REQ-007 m_wdata_i  input  128  master n write data at [32n+31:32n].
REQ-008 m_ack_o  output  4  per-master accept strobe.
REQ-009 m_rdata_o  output  32  read data, broadcast to all masters.
REQ-010 m_resp_o  output  4  per-master read-response strobe.
REQ-011 s_req_o, s_addr_o, s_cmd_o, s_wdata_o  output  1/32/1/32  slave request channel.
REQ-012 s_reqtid_o  output  2  index of the granted master.
REQ-013 s_ack_i  input  1  slave accepts the current request.
REQ-014 s_resp_i, s_resptid_i, s_rdata_i  input  1/2/32  slave read response and its tag.
REQ-015 outstanding_o  output  4  current count of outstanding reads.
REQ-016 err_o  output  1  sticky protocol-error flag.

Function
REQ-017 Transfer: a request transfers in a cycle with s_req_o=1 and s_ack_i=1; m_ack_o[g] = s_ack_i & s_req_o for granted master g, other m_ack_o bits = 0, same cycle (zero latency).
REQ-018 Request path: s_addr_o, s_cmd_o, s_wdata_o and s_reqtid_o are combinationally the granted master's fields and index g.
REQ-019 Arbitration: round-robin; search order starts at (last_grant+1) mod 4; last_grant updates to g only on a transfer.
REQ-020 Lock: FSM states IDLE and LOCKED.
- IDLE->LOCKED when s_req_o=1 and s_ack_i=0; the grant index is registered.
- LOCKED->IDLE on a transfer.
- LOCKED->IDLE if m_req_i[g] drops; this sets err_o.
REQ-021 In LOCKED, g is the registered index regardless of other requesters; in IDLE, g is the combinational round-robin winner.
REQ-022 Throttle: when outstanding = MAX_OUTSTANDING, a granted read is masked (s_req_o=0, no ack, no lock); writes still pass.
REQ-023 While a read is masked, arbitration skips masters whose pending request is a read, so a write from another master can be granted.
REQ-024 Counter: outstanding +1 on a read transfer, -1 on s_resp_i; both in the same cycle leaves it unchanged.
REQ-025 Writes never change the counter and never produce a response.
REQ-026 Response routing: m_resp_o[s_resptid_i] = s_resp_i combinationally; m_rdata_o = s_rdata_i always.
REQ-027 A response with outstanding = 0 leaves the counter at 0 (saturate) and sets err_o.
REQ-028 err_o clears only on reset.
REQ-029 No requests pending: s_req_o = 0, all m_ack_o = 0, FSM stays IDLE.

Reset
REQ-030 rst_i low asynchronously forces: FSM = IDLE, last_grant = 3 (master 0 has first priority), outstanding = 0, err_o = 0.
REQ-031 During reset, s_req_o = 0, m_ack_o = 0 and m_resp_o = 0 regardless of inputs.
REQ-032 Reset asserted mid-operation discards the lock and all outstanding tracking; late responses after release are treated per REQ-027.

Verification
REQ-033 Fairness: all 4 masters request reads with s_ack_i=1 every cycle -> grants 0,1,2,3,0 on consecutive cycles; s_reqtid_o matches each grant.
REQ-034 Lock: master 2 requests, s_ack_i=0 for 3 cycles, master 0 then also requests -> s_reqtid_o stays 2 until ack; master 0 is granted the cycle after.
REQ-035 Throttle: MAX_OUTSTANDING=4, 4 reads accepted and no responses -> outstanding_o=4; a 5th read from master 1 is held (s_req_o=0) while a write from master 3 is accepted; one response -> master 1's read is issued the next cycle.
REQ-036 Routing: s_resp_i=1, s_resptid_i=2, s_rdata_i=32'hDEADBEEF -> m_resp_o=4'b0100 and m_rdata_o=32'hDEADBEEF in the same cycle; read accept plus response in one cycle leaves outstanding_o unchanged.
REQ-037 Errors and reset: response with outstanding_o=0 -> err_o=1, counter stays 0; rst_i pulsed low while LOCKED with outstanding_o=3 -> counter=0, err_o=0, master 0 has highest priority after release.
